gf16_div_seq: RTL and testbench
===============================

Name: gf16_div_seq

Overview:
- Sequential GF(2^4) divider for the SMS4 composite-field S-box datapath; the inverse-direction companion to the GF(2^4) multiplier.
- Computes y = a · b^-1 over GF((2^2)^2) by Fermat exponentiation: b^-1 = b^14 = b^2·b^4·b^8.
- Uses one squarer and one multiplier, time-shared over 4 iterations.
- A start/done handshake lets the S-box control FSM issue inversions (a = 1) or general divisions.

Parameters:
- GF_N, 2'b10: GF(2^2) norm constant N in the extension polynomial z^2 + z + N. The default is the only verified value.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only when busy=0
- a  input  4  dividend {ah[3:2], al[1:0]}
- b  input  4  divisor {bh[3:2], bl[1:0]}
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; y valid
- y  output  4  quotient a/b, registered
- div_by_zero  output  1  present only with GF16_DIV_DZ_EN; see Optional Feature

Behaviour:
- GF(2^2) multiply, basis {x, 1}, modulus x^2 + x + 1:
  - hi = a1b1 ^ a1b0 ^ a0b1
  - lo = a1b1 ^ a0b0
  - Products: 2·2 = 3, 2·3 = 1, 3·3 = 2.
- GF(2^4) multiply p = a·b:
  - p[3:2] = (ah^al)·(bh^bl) ^ al·bl
  - p[1:0] = GF_N·(ah·bh) ^ al·bl
  - Multiplicative identity = 4'b0001.
- Reset (async, rst_n=0): state = IDLE; busy = 0, done = 0, y = 4'h0, div_by_zero = 0; internal regs cleared. Reset asserted mid-operation aborts the operation; no done is issued.
- States and transitions:
  - IDLE: start=1 at edge E0 → latch a_r = a, p = b, acc = 4'b0001; busy = 1; go to S1.
  - S1 (edge E1): p = p·p, acc = acc·p_new → p = b^2, acc = b^2.
  - S2 (edge E2): same update → p = b^4, acc = b^6.
  - S3 (edge E3): same update → p = b^8, acc = b^14.
  - FIN (edge E4): y = a_r·acc; done = 1 for exactly one cycle; busy = 0; return to IDLE.
- acc·p_new uses the squarer output of the same cycle (chained combinational path: squarer then multiplier).
- Latency: done is high in the cycle following E4, i.e. 4 clocks after the accepting edge.
- start while busy = 1 is ignored; the operation is not restarted and nothing is queued.
- start = 1 in the done cycle is accepted (busy = 0 then), giving back-to-back throughput of one result per 5 clocks.
- y holds its value until the next FIN edge or reset. a and b may change after E0 without effect.
- b = 0: b^14 = 0, so y = 0. This is the defined result, not X.
- a = 0: y = 0.
- a = 1: y = b^-1 (inversion mode).

Optional Feature:
- Macro GF16_DIV_DZ_EN.
- Defined:
  - div_by_zero port exists; it is registered at E0 as (b == 0).
  - It is valid from the done cycle and held until the next accepted start or reset.
  - y still = 0 on divide by zero.
- Undefined: the port and its register are absent; divide by zero silently yields y = 0.

Test Plan:
- Reset/idle: assert rst_n = 0 mid-operation (in S2) → busy = 0, done = 0, y = 0 immediately; no done pulse follows; after release, start works normally.
- Inversion: a = 4'b0001, b = 4'b0100 → done 4 clocks after the accepting edge, y = 4'b1111. Then a = 1, b = 4'b0010 → y = 4'b0011.
- Division: a = 4'b0110, b = 4'b0100 → y = 4'b0100; a = 4'b0000, b = 4'b0101 → y = 4'b0000.
- Divide by zero: a = 4'b0110, b = 4'b0000 → y = 4'b0000. With GF16_DIV_DZ_EN, div_by_zero = 1. A following valid op clears it to 0.
- Handshake: pulse start again during S1–S3 with different operands → ignored, result matches the first operands. Assert start in the done cycle → second op accepted, second done exactly 5 clocks after the first.
- Exhaustive: all 256 (a, b) pairs back-to-back, compared against a reference model using the formulas above. For b ≠ 0 check y·b == a; for b = 0 check y = 0.

Source files
------------

// File: rtl/gf16_div_seq.sv
// gf16_div_seq: sequential GF((2^2)^2) divider y = a * b^14, one squarer + one multiplier over 4 steps.
// Define GF16_DIV_DZ_EN to add the registered div_by_zero flag.
module gf16_div_seq #(
    parameter logic [1:0] GF_N = 2'b10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
`ifdef GF16_DIV_DZ_EN
    output logic       div_by_zero,
`endif
    output logic [3:0] y
);
    typedef enum logic [2:0] {IDLE, S1, S2, S3, FIN} state_t;

    function automatic logic [1:0] gf4_mul(input logic [1:0] x, input logic [1:0] w);
        return {x[1] & w[1] ^ x[1] & w[0] ^ x[0] & w[1], x[1] & w[1] ^ x[0] & w[0]};
    endfunction

    function automatic logic [3:0] gf16_mul(input logic [3:0] x, input logic [3:0] w);
        logic [1:0] ll;
        ll = gf4_mul(x[1:0], w[1:0]);
        return {gf4_mul(x[3:2] ^ x[1:0], w[3:2] ^ w[1:0]) ^ ll,
                gf4_mul(GF_N, gf4_mul(x[3:2], w[3:2])) ^ ll};
    endfunction

    state_t     state_q;
    logic [3:0] a_q, p_q, acc_q, y_q;
    logic       busy_q, done_q;
    logic [3:0] p_d, acc_d;

    // squarer feeds the accumulator multiplier in the same cycle
    assign p_d   = gf16_mul(p_q, p_q);
    assign acc_d = gf16_mul(acc_q, p_d);

`ifdef GF16_DIV_DZ_EN
    logic dz_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dz_q <= 1'b0;
        else if (state_q == IDLE && start) dz_q <= (b == 4'h0);
    assign div_by_zero = dz_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 4'h0;
            p_q     <= 4'h0;
            acc_q   <= 4'h0;
            y_q     <= 4'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    a_q     <= a;
                    p_q     <= b;
                    acc_q   <= 4'h1;
                    busy_q  <= 1'b1;
                    state_q <= S1;
                end
                S1, S2, S3: begin
                    p_q     <= p_d;
                    acc_q   <= acc_d;
                    state_q <= state_q == S3 ? FIN : state_t'(state_q + 3'd1);
                end
                FIN: begin
                    y_q     <= gf16_mul(a_q, acc_q);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;
endmodule

// File: tb/tb_gf16_div_seq.sv
// tb_gf16_div_seq: directed and exhaustive checks of gf16_div_seq against hand values and y*b == a.
module tb_gf16_div_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = 4'h0, b = 4'h0;
    logic       busy, done;
    logic [3:0] y;
`ifdef GF16_DIV_DZ_EN
    logic       div_by_zero;
`endif
    int total = 0, bad = 0;

    gf16_div_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done),
`ifdef GF16_DIV_DZ_EN
        .div_by_zero(div_by_zero),
`endif
        .y(y)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] m4(input logic [1:0] x, input logic [1:0] w);
        return {x[1] & w[1] ^ x[1] & w[0] ^ x[0] & w[1], x[1] & w[1] ^ x[0] & w[0]};
    endfunction

    function automatic logic [3:0] m16(input logic [3:0] x, input logic [3:0] w);
        return {m4(x[3:2] ^ x[1:0], w[3:2] ^ w[1:0]) ^ m4(x[1:0], w[1:0]),
                m4(2'b10, m4(x[3:2], w[3:2])) ^ m4(x[1:0], w[1:0])};
    endfunction

    task automatic launch(input logic [3:0] av, input logic [3:0] bv);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 12) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input string nm, input logic [3:0] av, input logic [3:0] bv, input logic [3:0] ev);
        int k;
        launch(av, bv);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s busy: got %b want 1", nm, busy); end
        wait_done(k);
        total++;
        if (k !== 4) begin bad++; $display("FAIL %s latency: got %0d want 4", nm, k); end
        total++;
        if (y !== ev) begin bad++; $display("FAIL %s y: got %b want %b", nm, y, ev); end
    endtask

    task automatic test_reset;
        int k;
        rst_n = 1'b0;
        #12;
        total++;
        if ({busy, done, y} !== 6'b0) begin bad++; $display("FAIL reset_init: got busy=%b done=%b y=%b want 0 0 0000", busy, done, y); end
        @(negedge clk); rst_n = 1'b1;
        run_op("pre_reset", 4'b0001, 4'b0100, 4'b1111);
        launch(4'b0001, 4'b0010);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, y} !== 6'b0) begin bad++; $display("FAIL reset_mid: got busy=%b done=%b y=%b want 0 0 0000", busy, done, y); end
        @(negedge clk); rst_n = 1'b1;
        k = 0;
        repeat (8) begin @(negedge clk); if (done) k++; end
        total++;
        if (k !== 0) begin bad++; $display("FAIL reset_no_done: got %0d pulses want 0", k); end
    endtask

    task automatic test_inversion;
        logic [3:0] yh;
        run_op("inv_4", 4'b0001, 4'b0100, 4'b1111);
        yh = y;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL done_pulse: got done=%b busy=%b want 0 0", done, busy); end
        repeat (2) @(negedge clk);
        total++;
        if (y !== 4'b1111) begin bad++; $display("FAIL y_hold: got %b want 1111", y); end
        run_op("inv_2", 4'b0001, 4'b0010, 4'b0011);
    endtask

    task automatic test_division;
        run_op("div_6_4", 4'b0110, 4'b0100, 4'b0100);
        run_op("div_0_5", 4'b0000, 4'b0101, 4'b0000);
    endtask

    task automatic test_div_zero;
        run_op("dz", 4'b0110, 4'b0000, 4'b0000);
`ifdef GF16_DIV_DZ_EN
        total++;
        if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag: got %b want 1", div_by_zero); end
        run_op("dz_clear", 4'b0001, 4'b0010, 4'b0011);
        total++;
        if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dz_clear_flag: got %b want 0", div_by_zero); end
`endif
    endtask

    task automatic test_ignore_busy;
        int k;
        launch(4'b0001, 4'b0010);
        @(negedge clk);
        a = 4'b0110; b = 4'b0100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 2;
        while (!done && k < 12) begin @(negedge clk); k++; end
        total++;
        if (k !== 4 || y !== 4'b0011) begin bad++; $display("FAIL ignore_busy: got k=%0d y=%b want 4 0011", k, y); end
        repeat (6) @(negedge clk);
        total++;
        if (busy !== 1'b0 || y !== 4'b0011) begin bad++; $display("FAIL ignore_no_queue: got busy=%b y=%b want 0 0011", busy, y); end
    endtask

    task automatic test_back_to_back;
        int k;
        run_op("b2b_first", 4'b0110, 4'b0100, 4'b0100);
        a = 4'b0001; b = 4'b0100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < 12) begin @(negedge clk); k++; end
        total++;
        if (k !== 5 || y !== 4'b1111) begin bad++; $display("FAIL back_to_back: got gap=%0d y=%b want 5 1111", k, y); end
    endtask

    task automatic test_exhaustive;
        int k;
        logic [3:0] av, bv;
        launch(4'h0, 4'h0);
        for (int i = 0; i < 256; i++) begin
            av = i[7:4]; bv = i[3:0];
            wait_done(k);
            total++;
            if (k > 4 || (bv != 4'h0 ? m16(y, bv) !== av : y !== 4'h0)) begin
                bad++;
                $display("FAIL exh a=%b b=%b: got y=%b lat=%0d want y*b==a (or 0)", av, bv, y, k);
            end
            if (i < 255) begin
                a = 4'((i + 1) >> 4); b = 4'((i + 1) & 15); start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset;
        test_inversion;
        test_division;
        test_div_zero;
        test_ignore_busy;
        test_back_to_back;
        test_exhaustive;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
